// File: rtl/div_sequencer_if.sv
// Handshake/bus bundle between the execute stage and the divide sequencer.
//   master : execute stage  -> drives start, a, b, control, signControl, kill
//   slave  : div_sequencer  -> drives busy, done, result
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             control;      // 0 = quotient, 1 = remainder
  logic             signControl;  // 0 = unsigned, 1 = signed
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a, b, control, signControl, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b, control, signControl, kill,
    output busy, done, result
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider/remainder sequencer.
// One quotient bit per cycle over WIDTH CALC cycles, then a FIXUP cycle that
// selects quotient or remainder and restores its sign. Divide-by-zero and
// signed overflow finish straight from acceptance (result written on the
// accepting edge, done in the next cycle).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - div_sequencer_if.slave: start/a/b/control/signControl/kill in,
//          busy/done/result out
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  div_sequencer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;        // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] r_q, r_d;        // partial remainder; always < |b|, so WIDTH bits hold it
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ctrl_q, ctrl_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic             a_neg, b_neg;
  logic             ovf;
  logic [WIDTH:0]   r_shift;         // WIDTH+1-bit shifted partial remainder
  logic [WIDTH-1:0] r_sub;
  logic [WIDTH-1:0] sel;
  logic             sel_neg;

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    r_d      = r_q;
    bmag_d   = bmag_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    sel      = '0;
    sel_neg  = 1'b0;

    accept  = bus.start && !bus.kill && (state_q == S_IDLE || state_q == S_DONE);
    a_neg   = bus.signControl && bus.a[WIDTH-1];
    b_neg   = bus.signControl && bus.b[WIDTH-1];
    ovf     = bus.signControl && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.b);

    r_shift = {r_q, q_q[WIDTH-1]};
    // True difference is < |b| whenever it is taken, so modulo-2^WIDTH is exact.
    r_sub   = r_shift[WIDTH-1:0] - bmag_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          ctrl_d = bus.control;
          if (bus.b == '0) begin
            result_d = bus.control ? bus.a : '1;
            state_d  = S_DONE;
          end else if (ovf) begin
            // Quotient of MIN / -1 wraps to MIN, which is the dividend itself.
            result_d = bus.control ? '0 : bus.a;
            state_d  = S_DONE;
          end else begin
            q_d     = a_neg ? -bus.a : bus.a;
            bmag_d  = b_neg ? -bus.b : bus.b;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            r_d     = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (r_shift >= {1'b0, bmag_q}) begin
          r_d = r_sub;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_shift[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIXUP;
      end

      S_FIXUP: begin
        sel      = ctrl_q ? r_q : q_q;
        sel_neg  = ctrl_q ? negr_q : negq_q;
        result_d = sel_neg ? -sel : sel;
        state_d  = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase

    // Flush beats everything except reset; an aborted op never writes result.
    if (bus.kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      r_q      <= '0;
      bmag_q   <= '0;
      cnt_q    <= '0;
      ctrl_q   <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      r_q      <= r_d;
      bmag_q   <= bmag_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus randomized
// operations checked against a plain-arithmetic RISC-V DIV/REM model.
module tb_div_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(32)) dif ();

  div_sequencer #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ctrl, input logic sgn);
    longint x, y, q, r;
    if (b == 32'd0) return ctrl ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return ctrl ? r[31:0] : q[31:0];
  endfunction

  function automatic int latency(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    if (b == 32'd0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue an op in the current cycle (cycle 0) and follow it to done.
  // Returns positioned in the done cycle so the next call is back-to-back.
  // hold: keep start asserted (with other operands) through most of CALC.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ctrl, input logic sgn, input bit hold);
    logic [31:0] exp, prev;
    int n, busy_cnt, lat;
    bit held_ok;
    exp  = model(a, b, ctrl, sgn);
    lat  = latency(a, b, sgn);
    prev = dif.result;
    dif.a = a; dif.b = b; dif.control = ctrl; dif.signControl = sgn;
    dif.start = 1'b1;
    tick();
    if (hold) begin
      dif.a = ~a; dif.b = 32'd0; dif.control = ~ctrl;
    end else begin
      dif.start = 1'b0;
    end
    n = 1; busy_cnt = 0; held_ok = 1'b1;
    while (!dif.done && n < 60) begin
      if (dif.busy) busy_cnt++;
      if (dif.result !== prev) held_ok = 1'b0;
      if (hold && n == 30) dif.start = 1'b0;
      tick();
      n++;
    end
    dif.start = 1'b0;
    check({tag, "_done"}, 32'(dif.done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_result"}, dif.result, exp);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
    check({tag, "_busy_at_done"}, 32'(dif.busy), 32'd0);
    check({tag, "_result_held"}, 32'(held_ok), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb, prev;
    int sel, dn;

    rst = 1'b1;
    dif.start = 1'b0; dif.a = '0; dif.b = '0;
    dif.control = 1'b0; dif.signControl = 1'b0; dif.kill = 1'b0;
    tick(); tick();
    check("reset_busy", 32'(dif.busy), 32'd0);
    check("reset_done", 32'(dif.done), 32'd0);
    check("reset_result", dif.result, 32'd0);
    rst = 1'b0;
    tick();

    run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    run_op("urem_100_7", 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);   // start in DONE cycle
    check("urem_value", dif.result, 32'd2);
    run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b0);
    check("sdiv_m7_2_value", dif.result, 32'hFFFF_FFFD);
    run_op("srem_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0);
    check("srem_m7_2_value", dif.result, 32'hFFFF_FFFF);
    run_op("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
    check("sdiv_7_m2_value", dif.result, 32'hFFFF_FFFD);
    run_op("srem_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
    check("srem_7_m2_value", dif.result, 32'd1);
    run_op("udivz", 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0);
    check("udivz_value", dif.result, 32'hFFFF_FFFF);
    run_op("uremz", 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op("sdivz", 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1'b0);
    run_op("sremz", 32'h1234_5678, 32'd0, 1'b1, 1'b1, 1'b0);
    check("sremz_value", dif.result, 32'h1234_5678);
    run_op("sovf_div", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    check("sovf_div_value", dif.result, 32'h8000_0000);
    run_op("sovf_rem", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("uovf_div", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check("uovf_div_value", dif.result, 32'd0);
    tick();
    run_op("hold_start", 32'd1000, 32'd9, 1'b0, 1'b0, 1'b1);
    tick();
    check("hold_no_retrigger", 32'(dif.busy | dif.done), 32'd0);

    // kill in CALC cycle 10, with a start in the same cycle
    prev = dif.result;
    dif.a = 32'd100; dif.b = 32'd7; dif.control = 1'b1; dif.signControl = 1'b0;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    repeat (9) tick();
    check("kill_busy_before", 32'(dif.busy), 32'd1);
    dif.kill = 1'b1; dif.start = 1'b1; dif.a = 32'd5; dif.b = 32'd0;
    tick();
    dif.kill = 1'b0; dif.start = 1'b0;
    check("kill_busy_after", 32'(dif.busy), 32'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (dif.done || dif.busy) dn++;
      tick();
    end
    check("kill_no_activity", 32'(dn), 32'd0);
    check("kill_result_kept", dif.result, prev);
    run_op("after_kill", 32'd12345, 32'd10, 1'b0, 1'b0, 1'b0);

    // synchronous reset in the middle of CALC
    tick();
    dif.a = 32'd77; dif.b = 32'd5; dif.control = 1'b0; dif.signControl = 1'b0;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(dif.busy), 32'd0);
    check("rst_done", 32'(dif.done), 32'd0);
    check("rst_result", dif.result, 32'd0);
    tick();

    // randomized operations, mixing back-to-back and idle-gap issue
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) rb = rb >> $urandom_range(31);
      run_op("rand", ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
      if ($urandom_range(1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
